// File: rtl/rv32i_enc_pkg.sv
// ============================================================================
// Module : rv32i_enc_pkg
// Brief  : Mnemonic codes, opcode/funct constants, format enum and decoder
//          shared by the RV32I instruction encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv32i_enc_pkg;

    localparam logic [5:0] MN_LUI   = 6'd0;
    localparam logic [5:0] MN_AUIPC = 6'd1;
    localparam logic [5:0] MN_JAL   = 6'd2;
    localparam logic [5:0] MN_JALR  = 6'd3;
    localparam logic [5:0] MN_BEQ   = 6'd4;
    localparam logic [5:0] MN_BNE   = 6'd5;
    localparam logic [5:0] MN_BLT   = 6'd6;
    localparam logic [5:0] MN_BGE   = 6'd7;
    localparam logic [5:0] MN_BLTU  = 6'd8;
    localparam logic [5:0] MN_BGEU  = 6'd9;
    localparam logic [5:0] MN_LB    = 6'd10;
    localparam logic [5:0] MN_LH    = 6'd11;
    localparam logic [5:0] MN_LW    = 6'd12;
    localparam logic [5:0] MN_LBU   = 6'd13;
    localparam logic [5:0] MN_LHU   = 6'd14;
    localparam logic [5:0] MN_SB    = 6'd15;
    localparam logic [5:0] MN_SH    = 6'd16;
    localparam logic [5:0] MN_SW    = 6'd17;
    localparam logic [5:0] MN_ADDI  = 6'd18;
    localparam logic [5:0] MN_SLTI  = 6'd19;
    localparam logic [5:0] MN_SLTIU = 6'd20;
    localparam logic [5:0] MN_XORI  = 6'd21;
    localparam logic [5:0] MN_ORI   = 6'd22;
    localparam logic [5:0] MN_ANDI  = 6'd23;
    localparam logic [5:0] MN_SLLI  = 6'd24;
    localparam logic [5:0] MN_SRLI  = 6'd25;
    localparam logic [5:0] MN_SRAI  = 6'd26;
    localparam logic [5:0] MN_ADD   = 6'd27;
    localparam logic [5:0] MN_SUB   = 6'd28;
    localparam logic [5:0] MN_SLL   = 6'd29;
    localparam logic [5:0] MN_SLT   = 6'd30;
    localparam logic [5:0] MN_SLTU  = 6'd31;
    localparam logic [5:0] MN_XOR   = 6'd32;
    localparam logic [5:0] MN_SRL   = 6'd33;
    localparam logic [5:0] MN_SRA   = 6'd34;
    localparam logic [5:0] MN_OR    = 6'd35;
    localparam logic [5:0] MN_AND   = 6'd36;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_SH = 3'd2,
        FMT_S  = 3'd3,
        FMT_B  = 3'd4,
        FMT_U  = 3'd5,
        FMT_J  = 3'd6
    } fmt_t;

    typedef struct packed {
        logic       valid;
        fmt_t       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } dec_t;

    function automatic dec_t decode_mnem(input logic [5:0] mnem);
        dec_t d;
        d = '{valid: 1'b1, fmt: FMT_R, opcode: 7'd0, funct3: 3'd0, funct7: F7_BASE};
        case (mnem)
            MN_LUI:   begin d.fmt = FMT_U;  d.opcode = OP_LUI;                      end
            MN_AUIPC: begin d.fmt = FMT_U;  d.opcode = OP_AUIPC;                    end
            MN_JAL:   begin d.fmt = FMT_J;  d.opcode = OP_JAL;                      end
            MN_JALR:  begin d.fmt = FMT_I;  d.opcode = OP_JALR;                     end
            MN_BEQ:   begin d.fmt = FMT_B;  d.opcode = OP_BRANCH; d.funct3 = 3'd0;  end
            MN_BNE:   begin d.fmt = FMT_B;  d.opcode = OP_BRANCH; d.funct3 = 3'd1;  end
            MN_BLT:   begin d.fmt = FMT_B;  d.opcode = OP_BRANCH; d.funct3 = 3'd4;  end
            MN_BGE:   begin d.fmt = FMT_B;  d.opcode = OP_BRANCH; d.funct3 = 3'd5;  end
            MN_BLTU:  begin d.fmt = FMT_B;  d.opcode = OP_BRANCH; d.funct3 = 3'd6;  end
            MN_BGEU:  begin d.fmt = FMT_B;  d.opcode = OP_BRANCH; d.funct3 = 3'd7;  end
            MN_LB:    begin d.fmt = FMT_I;  d.opcode = OP_LOAD;   d.funct3 = 3'd0;  end
            MN_LH:    begin d.fmt = FMT_I;  d.opcode = OP_LOAD;   d.funct3 = 3'd1;  end
            MN_LW:    begin d.fmt = FMT_I;  d.opcode = OP_LOAD;   d.funct3 = 3'd2;  end
            MN_LBU:   begin d.fmt = FMT_I;  d.opcode = OP_LOAD;   d.funct3 = 3'd4;  end
            MN_LHU:   begin d.fmt = FMT_I;  d.opcode = OP_LOAD;   d.funct3 = 3'd5;  end
            MN_SB:    begin d.fmt = FMT_S;  d.opcode = OP_STORE;  d.funct3 = 3'd0;  end
            MN_SH:    begin d.fmt = FMT_S;  d.opcode = OP_STORE;  d.funct3 = 3'd1;  end
            MN_SW:    begin d.fmt = FMT_S;  d.opcode = OP_STORE;  d.funct3 = 3'd2;  end
            MN_ADDI:  begin d.fmt = FMT_I;  d.opcode = OP_IMM;    d.funct3 = 3'd0;  end
            MN_SLTI:  begin d.fmt = FMT_I;  d.opcode = OP_IMM;    d.funct3 = 3'd2;  end
            MN_SLTIU: begin d.fmt = FMT_I;  d.opcode = OP_IMM;    d.funct3 = 3'd3;  end
            MN_XORI:  begin d.fmt = FMT_I;  d.opcode = OP_IMM;    d.funct3 = 3'd4;  end
            MN_ORI:   begin d.fmt = FMT_I;  d.opcode = OP_IMM;    d.funct3 = 3'd6;  end
            MN_ANDI:  begin d.fmt = FMT_I;  d.opcode = OP_IMM;    d.funct3 = 3'd7;  end
            MN_SLLI:  begin d.fmt = FMT_SH; d.opcode = OP_IMM;    d.funct3 = 3'd1;  end
            MN_SRLI:  begin d.fmt = FMT_SH; d.opcode = OP_IMM;    d.funct3 = 3'd5;  end
            MN_SRAI:  begin d.fmt = FMT_SH; d.opcode = OP_IMM;    d.funct3 = 3'd5; d.funct7 = F7_ALT; end
            MN_ADD:   begin d.opcode = OP_REG; d.funct3 = 3'd0;                     end
            MN_SUB:   begin d.opcode = OP_REG; d.funct3 = 3'd0; d.funct7 = F7_ALT;  end
            MN_SLL:   begin d.opcode = OP_REG; d.funct3 = 3'd1;                     end
            MN_SLT:   begin d.opcode = OP_REG; d.funct3 = 3'd2;                     end
            MN_SLTU:  begin d.opcode = OP_REG; d.funct3 = 3'd3;                     end
            MN_XOR:   begin d.opcode = OP_REG; d.funct3 = 3'd4;                     end
            MN_SRL:   begin d.opcode = OP_REG; d.funct3 = 3'd5;                     end
            MN_SRA:   begin d.opcode = OP_REG; d.funct3 = 3'd5; d.funct7 = F7_ALT;  end
            MN_OR:    begin d.opcode = OP_REG; d.funct3 = 3'd6;                     end
            MN_AND:   begin d.opcode = OP_REG; d.funct3 = 3'd7;                     end
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_pack_rv32i.sv
// ============================================================================
// Module : imm_pack_rv32i
// Brief  : Scatters an immediate into its RV32I instruction bit positions and
//          range-checks it when ENC_RANGE_CHECK_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_pack_rv32i
    import rv32i_enc_pkg::*;
(
    input  fmt_t        fmt,
    input  logic [31:0] in_imm,
    output logic [31:0] imm_bits,
    output logic        range_err
);

    always_comb begin
        imm_bits = 32'd0;
        case (fmt)
            FMT_I:   imm_bits[31:20] = in_imm[11:0];
            FMT_SH:  imm_bits[24:20] = in_imm[4:0];
            FMT_S:   begin
                imm_bits[31:25] = in_imm[11:5];
                imm_bits[11:7]  = in_imm[4:0];
            end
            FMT_B:   begin
                imm_bits[31]    = in_imm[12];
                imm_bits[30:25] = in_imm[10:5];
                imm_bits[11:8]  = in_imm[4:1];
                imm_bits[7]     = in_imm[11];
            end
            FMT_U:   imm_bits[31:12] = in_imm[31:12];
            FMT_J:   begin
                imm_bits[31]    = in_imm[20];
                imm_bits[30:21] = in_imm[10:1];
                imm_bits[20]    = in_imm[11];
                imm_bits[19:12] = in_imm[19:12];
            end
            default: imm_bits = 32'd0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // A value fits an N-bit signed field when all bits above the sign bit match it.
    logic w_fit12, w_fit13, w_fit21;
    assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = ~w_fit12;
            FMT_SH:       range_err = |in_imm[31:5];
            FMT_B:        range_err = in_imm[0] | ~w_fit13;
            FMT_J:        range_err = in_imm[0] | ~w_fit21;
            FMT_U:        range_err = |in_imm[11:0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/instr_encoder_rv32i.sv
// ============================================================================
// Module : instr_encoder_rv32i
// Brief  : Encodes RV32I mnemonics into machine words and writes them to
//          sequential instruction-memory addresses. ENC_RANGE_CHECK_EN enables
//          immediate range errors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_encoder_rv32i
    import rv32i_enc_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_mnem,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [15:0] word_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    logic [1:0]  r_state;
    logic        r_ready_en;
    logic [5:0]  r_mnem;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [31:0] r_imm;
    logic [31:0] r_word;
    logic        r_err;
    logic [31:0] r_addr;
    logic [15:0] r_count;

    dec_t        w_dec;
    logic [31:0] w_imm_bits;
    logic        w_range_err;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_word;
    logic        w_err;
    logic        w_unused;

    assign w_unused = ^base_addr[1:0];
    assign w_dec    = decode_mnem(r_mnem);

    imm_pack_rv32i u_imm_pack (
        .fmt       (w_dec.fmt),
        .in_imm    (r_imm),
        .imm_bits  (w_imm_bits),
        .range_err (w_range_err)
    );

    // Register fields absent from the format are forced to zero.
    assign w_rd  = (w_dec.fmt == FMT_S || w_dec.fmt == FMT_B) ? 5'd0 : r_rd;
    assign w_rs1 = (w_dec.fmt == FMT_U || w_dec.fmt == FMT_J) ? 5'd0 : r_rs1;
    assign w_rs2 = (w_dec.fmt == FMT_R || w_dec.fmt == FMT_S || w_dec.fmt == FMT_B) ? r_rs2 : 5'd0;

    assign w_word = w_imm_bits
                  | {w_dec.funct7, w_rs2, w_rs1, w_dec.funct3, w_rd, w_dec.opcode};
    assign w_err  = ~w_dec.valid | w_range_err;

    // r_ready_en holds in_ready low until the first edge after reset release.
    assign in_ready   = r_ready_en && (r_state == ST_IDLE) && !start;
    assign resp_valid = (r_state == ST_WRITE);
    assign resp_err   = resp_valid && r_err;
    assign mem_we     = resp_valid && !r_err;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_word;
    assign word_count = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ready_en <= 1'b0;
            r_mnem     <= 6'd0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_imm      <= 32'd0;
            r_word     <= 32'd0;
            r_err      <= 1'b0;
            r_addr     <= 32'd0;
            r_count    <= 16'd0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= {base_addr[31:2], 2'b00};
                        r_count <= 16'd0;
                    end else if (in_valid && in_ready) begin
                        r_mnem  <= in_mnem;
                        r_rd    <= in_rd;
                        r_rs1   <= in_rs1;
                        r_rs2   <= in_rs2;
                        r_imm   <= in_imm;
                        r_state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    r_err <= w_err;
                    if (!w_err) begin
                        r_word <= w_word;
                    end
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!r_err) begin
                        r_addr <= r_addr + 32'd4;
                        if (r_count != 16'hFFFF) begin
                            r_count <= r_count + 16'd1;
                        end
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_rv32i.sv
// ============================================================================
// Module : tb_instr_encoder_rv32i
// Brief  : Table-driven bench for instr_encoder_rv32i with reset, wrap and
//          abort sequences. Expectations follow ENC_RANGE_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder_rv32i;
    import rv32i_enc_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_mnem = 6'd0;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        resp_valid, resp_err;
    logic [15:0] word_count;

    always #5 clock = ~clock;

    instr_encoder_rv32i dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mnem    (in_mnem),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .word_count (word_count)
    );

    typedef struct packed {
        logic [5:0]  mnem;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t        vecs [NVEC];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_addr = 32'd0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] base);
        @(negedge clock);
        start     = 1'b1;
        base_addr = base;
        #1 chk("ready_low_on_start", 32'(in_ready), 32'd0);
        @(negedge clock);
        start    = 1'b0;
        exp_addr = {base[31:2], 2'b00};
        exp_cnt  = 16'd0;
        chk("start_addr", mem_addr, exp_addr);
        chk("start_count", 32'(word_count), 32'(exp_cnt));
    endtask

    task automatic do_req(input vec_t v, input string nm);
        int n;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_mnem  = v.mnem;
        in_rd    = v.rd;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
        in_imm   = v.imm;
        @(negedge clock);
        in_valid = 1'b0;
        chk({nm, "_encode_no_resp"}, 32'(resp_valid), 32'd0);
        @(negedge clock);
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_resp_err"}, 32'(resp_err), 32'(v.err));
        chk({nm, "_mem_we"}, 32'(mem_we), 32'(!v.err));
        chk({nm, "_mem_addr"}, mem_addr, exp_addr);
        if (!v.err) chk({nm, "_wdata"}, mem_wdata, v.word);
        @(negedge clock);
        if (!v.err) begin
            exp_addr = exp_addr + 32'd4;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        chk({nm, "_we_one_cycle"}, 32'(mem_we), 32'd0);
        chk({nm, "_resp_one_cycle"}, 32'(resp_valid), 32'd0);
        chk({nm, "_next_addr"}, mem_addr, exp_addr);
        chk({nm, "_count"}, 32'(word_count), 32'(exp_cnt));
    endtask

    initial begin
        int hits;
        vecs[0]  = '{MN_ADDI,  5'd1,  5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0};
        vecs[1]  = '{MN_ADD,   5'd3,  5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b0};
        vecs[2]  = '{MN_SUB,   5'd3,  5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0};
        vecs[3]  = '{MN_BEQ,   5'd0,  5'd1, 5'd2, 32'd8,          32'h00208463, 1'b0};
        vecs[4]  = '{MN_JAL,   5'd1,  5'd0, 5'd0, 32'd2048,       32'h001000EF, 1'b0};
        vecs[5]  = '{MN_SRAI,  5'd5,  5'd5, 5'd0, 32'd3,          32'h4032D293, 1'b0};
        vecs[6]  = '{MN_LUI,   5'd2,  5'd0, 5'd0, 32'h12345000,   32'h12345137, 1'b0};
        vecs[7]  = '{MN_LW,    5'd6,  5'd7, 5'd0, 32'hFFFFFFFC,   32'hFFC3A303, 1'b0};
        vecs[8]  = '{MN_SW,    5'd0,  5'd2, 5'd5, 32'd8,          32'h00512423, 1'b0};
        vecs[9]  = '{MN_AUIPC, 5'd10, 5'd0, 5'd0, 32'h00001000,   32'h00001517, 1'b0};
        vecs[10] = '{MN_BNE,   5'd0,  5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE209EE3, 1'b0};
`ifdef ENC_RANGE_CHECK_EN
        vecs[11] = '{MN_ADDI,  5'd1,  5'd0, 5'd0, 32'd2048,       32'h80000093, 1'b1};
`else
        vecs[11] = '{MN_ADDI,  5'd1,  5'd0, 5'd0, 32'd2048,       32'h80000093, 1'b0};
`endif
        vecs[12] = '{6'd40,    5'd1,  5'd1, 5'd1, 32'd0,          32'h00000000, 1'b1};
        vecs[13] = '{MN_JALR,  5'd1,  5'd5, 5'd0, 32'd0,          32'h000280E7, 1'b0};
        vecs[14] = '{MN_SLLI,  5'd1,  5'd1, 5'd0, 32'd31,         32'h01F09093, 1'b0};
        vecs[15] = '{MN_AND,   5'd4,  5'd5, 5'd6, 32'd0,          32'h0062F233, 1'b0};

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        reset_n = 1'b1;
        #1 chk("ready_before_first_edge", 32'(in_ready), 32'd0);
        @(negedge clock);
        chk("ready_after_first_edge", 32'(in_ready), 32'd1);

        do_start(32'h00000100);
        for (int i = 0; i < NVEC; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i));
        end

        // Address wrap; low base bits are discarded
        do_start(32'hFFFFFFFF);
        chk("wrap_base", mem_addr, 32'hFFFFFFFC);
        do_req(vecs[0], "wrap0");
        do_req(vecs[1], "wrap1");
        chk("wrap_final_addr", mem_addr, 32'h00000004);

        // start has priority over in_valid in IDLE
        @(negedge clock);
        start     = 1'b1;
        base_addr = 32'h00000200;
        in_valid  = 1'b1;
        in_mnem   = MN_ADD;
        @(negedge clock);
        start    = 1'b0;
        in_valid = 1'b0;
        exp_addr = 32'h00000200;
        exp_cnt  = 16'd0;
        hits = 0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid || mem_we) hits++;
        end
        chk("start_priority_no_resp", 32'(hits), 32'd0);
        chk("start_priority_addr", mem_addr, 32'h00000200);

        // Reset during ENCODE aborts the request
        while (!in_ready) @(negedge clock);
        in_valid = 1'b1;
        in_mnem  = MN_ADDI;
        in_rd    = 5'd1;
        in_imm   = 32'd5;
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1 chk("abort_resp_in_reset", 32'(resp_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        hits = 0;
        repeat (4) begin
            @(negedge clock);
            if (resp_valid || mem_we) hits++;
        end
        chk("abort_no_write", 32'(hits), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_count", 32'(word_count), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
